reg_stack: RTL and testbench

Parametrised hardware LIFO register stack for the stack CPU datapath, generalising the single 16-bit register into WIDTH-bit storage of DEPTH entries.
- Supports push, pop and replace-top operations, all in one cycle.
- Presents top-of-stack combinationally from registered state.
- Flags full/empty and reports sticky overflow/underflow errors to the control unit.
- Sits between the ALU result bus and the ALU operand inputs.

---
 rtl/reg_stack.sv | 121 ++++++++++++
 tb/tb_reg_stack.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/reg_stack.sv
// Parametrised LIFO register stack feeding the ALU operand inputs from the result bus.
// Optional next-of-stack port and double-pop input are enabled by defining REG_STACK_NOS_EN.
module reg_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
`ifdef REG_STACK_NOS_EN
  input  logic             pop2,
  output logic [WIDTH-1:0] nos,
`endif
  input  logic [WIDTH-1:0] din,
  input  logic             clr_err,
  output logic [WIDTH-1:0] tos,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [AW-1:0]    top_idx;
  logic             is_empty, is_full;
  logic             pop2_op;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_W'(DEPTH));
  // Only meaningful when non-empty; the wrapped value at count 0 is never used.
  assign top_idx  = AW'(count_q - CNT_W'(1));

`ifdef REG_STACK_NOS_EN
  assign pop2_op = pop2;
  assign nos     = (count_q >= CNT_W'(2)) ? mem_q[AW'(count_q - CNT_W'(2))] : '0;
`else
  assign pop2_op = 1'b0;
`endif

  always_comb begin
    count_d     = count_q;
    overflow_d  = clr_err ? 1'b0 : overflow_q;
    underflow_d = clr_err ? 1'b0 : underflow_q;
    mem_we      = 1'b0;
    mem_waddr   = top_idx;

    // Error setting comes after the clear so a new error in the same cycle wins.
    if (pop2_op) begin
      if (count_q >= CNT_W'(2)) begin
        if (push) begin
          count_d   = count_q - CNT_W'(1);
          mem_we    = 1'b1;
          mem_waddr = AW'(count_q - CNT_W'(2));
        end else begin
          count_d = count_q - CNT_W'(2);
        end
      end else begin
        underflow_d = 1'b1;
      end
    end else begin
      case ({push, pop})
        2'b10: begin
          if (!is_full) begin
            mem_we    = 1'b1;
            mem_waddr = AW'(count_q);
            count_d   = count_q + CNT_W'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end
        2'b01: begin
          if (!is_empty) count_d = count_q - CNT_W'(1);
          else           underflow_d = 1'b1;
        end
        2'b11: begin
          mem_we = 1'b1;
          if (is_empty) begin
            mem_waddr = '0;
            count_d   = CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately not reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem_q[mem_waddr] <= din;
  end

  assign tos       = is_empty ? '0 : mem_q[top_idx];
  assign count     = count_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_reg_stack.sv
// Directed bench for reg_stack at WIDTH=16, DEPTH=4.
module tb_reg_stack;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset, push, pop, clr_err;
  logic [WIDTH-1:0]  din, tos;
  logic [2:0]        count;
  logic              empty, full, overflow, underflow;
`ifdef REG_STACK_NOS_EN
  logic              pop2 = 1'b0;
  logic [WIDTH-1:0]  nos;
`endif

  int checks = 0;
  int errors = 0;

  reg_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop),
`ifdef REG_STACK_NOS_EN
    .pop2(pop2), .nos(nos),
`endif
    .din(din), .clr_err(clr_err), .tos(tos), .count(count),
    .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Drive one operation across a rising edge, then return 1 time unit after it.
  task automatic cyc(input logic pu, input logic po, input logic [WIDTH-1:0] d, input logic ce);
    push = pu; pop = po; din = d; clr_err = ce;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0; clr_err = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; push = 1'b0; pop = 1'b0; clr_err = 1'b0; din = '0;
    #12;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (tos !== 16'h0) begin errors++; $display("FAIL reset_tos got %h want 0000", tos); end
    checks++; if ({empty, full} !== 2'b10) begin errors++; $display("FAIL reset_flags empty/full got %b want 10", {empty, full}); end
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_err got %b want 00", {overflow, underflow}); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_push_fill;
    logic [WIDTH-1:0] vals [4];
    vals = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, vals[i], 1'b0);
      checks++; if (tos !== vals[i]) begin errors++; $display("FAIL fill_tos[%0d] got %h want %h", i, tos, vals[i]); end
      checks++; if (count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i + 1); end
      checks++; if (full !== (i == 3)) begin errors++; $display("FAIL fill_full[%0d] got %b want %b", i, full, (i == 3)); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_ovf[%0d] got %b want 0", i, overflow); end
    end
  endtask

  task automatic test_overflow;
    cyc(1'b1, 1'b0, 16'h5555, 1'b0);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count got %0d want 4", count); end
    checks++; if (tos !== 16'h4444) begin errors++; $display("FAIL ovf_tos got %h want 4444", tos); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow); end
    cyc(1'b0, 1'b0, 16'h0, 1'b1);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", overflow); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_clear_count got %0d want 4", count); end
    // Clear and a fresh overflow in the same cycle: the flag must end up set.
    cyc(1'b1, 1'b0, 16'h6666, 1'b1);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_error_wins got %b want 1", overflow); end
    cyc(1'b0, 1'b0, 16'h0, 1'b1);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_reclear got %b want 0", overflow); end
  endtask

  task automatic test_pop_drain;
    logic [WIDTH-1:0] exp_tos [4];
    exp_tos = '{16'h3333, 16'h2222, 16'h1111, 16'h0000};
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 16'h0, 1'b0);
      checks++; if (tos !== exp_tos[i]) begin errors++; $display("FAIL drain_tos[%0d] got %h want %h", i, tos, exp_tos[i]); end
      checks++; if (count !== 3'(3 - i)) begin errors++; $display("FAIL drain_count[%0d] got %0d want %0d", i, count, 3 - i); end
    end
    checks++; if ({empty, underflow} !== 2'b10) begin errors++; $display("FAIL drain_empty/unf got %b want 10", {empty, underflow}); end
    cyc(1'b0, 1'b1, 16'h0, 1'b0);
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL unf_set got %b want 1", underflow); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL unf_count got %0d want 0", count); end
  endtask

  task automatic test_replace_empty;
    cyc(1'b0, 1'b0, 16'h0, 1'b1);
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL unf_clear got %b want 0", underflow); end
    cyc(1'b1, 1'b1, 16'hABCD, 1'b0);
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL rep_empty_count got %0d want 1", count); end
    checks++; if (tos !== 16'hABCD) begin errors++; $display("FAIL rep_empty_tos got %h want abcd", tos); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL rep_empty_unf got %b want 0", underflow); end
    cyc(1'b1, 1'b1, 16'h1234, 1'b0);
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL rep_one_count got %0d want 1", count); end
    checks++; if (tos !== 16'h1234) begin errors++; $display("FAIL rep_one_tos got %h want 1234", tos); end
  endtask

  task automatic test_replace_full;
    logic [WIDTH-1:0] exp_tos [3];
    exp_tos = '{16'hA002, 16'hA001, 16'h1234};
    cyc(1'b1, 1'b0, 16'hA001, 1'b0);
    cyc(1'b1, 1'b0, 16'hA002, 1'b0);
    cyc(1'b1, 1'b0, 16'hA003, 1'b0);
    checks++; if ({full, tos} !== {1'b1, 16'hA003}) begin errors++; $display("FAIL refill full/tos got %b/%h want 1/a003", full, tos); end
    cyc(1'b1, 1'b1, 16'hBEEF, 1'b0);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL rep_full_count got %0d want 4", count); end
    checks++; if (tos !== 16'hBEEF) begin errors++; $display("FAIL rep_full_tos got %h want beef", tos); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rep_full_ovf got %b want 0", overflow); end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 16'h0, 1'b0);
      checks++; if (tos !== exp_tos[i]) begin errors++; $display("FAIL rep_pop_tos[%0d] got %h want %h", i, tos, exp_tos[i]); end
    end
    cyc(1'b0, 1'b1, 16'h0, 1'b0);
    cyc(1'b0, 1'b1, 16'h0, 1'b0);
    checks++; if ({empty, underflow} !== 2'b11) begin errors++; $display("FAIL rep_unf got %b want 11", {empty, underflow}); end
    cyc(1'b1, 1'b0, 16'h7777, 1'b0);
    cyc(1'b0, 1'b1, 16'h0, 1'b1);
    checks++; if ({count, underflow} !== {3'd0, 1'b0}) begin errors++; $display("FAIL pop_clr count/unf got %0d/%b want 0/0", count, underflow); end
    cyc(1'b0, 1'b1, 16'h0, 1'b1);
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL unf_error_wins got %b want 1", underflow); end
  endtask

  task automatic test_async_reset;
    cyc(1'b1, 1'b0, 16'h0C01, 1'b0);
    cyc(1'b1, 1'b0, 16'h0C02, 1'b0);
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL pre_reset_count got %0d want 2", count); end
    push = 1'b1; din = 16'h0C03;
    #2 reset = 1'b1;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL async_count got %0d want 0", count); end
    checks++; if (tos !== 16'h0) begin errors++; $display("FAIL async_tos got %h want 0000", tos); end
    checks++; if ({empty, underflow} !== 2'b10) begin errors++; $display("FAIL async_flags got %b want 10", {empty, underflow}); end
    @(posedge clk); #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_held_count got %0d want 0", count); end
    @(negedge clk); reset = 1'b0; push = 1'b0;
    cyc(1'b1, 1'b0, 16'h0D01, 1'b0);
    checks++; if ({count, tos} !== {3'd1, 16'h0D01}) begin errors++; $display("FAIL post_reset count/tos got %0d/%h want 1/0d01", count, tos); end
  endtask

  initial begin
    test_reset;
    test_push_fill;
    test_overflow;
    test_pop_drain;
    test_replace_empty;
    test_replace_full;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
